// File: rtl/pri_arb.sv
// pri_arb: registered N-way arbiter, fixed or round-robin priority, with max-hold preemption
module pri_arb #(
  parameter int N = 8,
  parameter int MAX_HOLD = 16,
  localparam int IW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          mode_i,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);
  localparam int HW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [IW-1:0] ptr, ptr_n, idx_n, win, start, j;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [N-1:0] gnt_n, cand;
  logic arb, any, limit;
  always_comb begin
    cand = req_i & ~gnt_o;
    any = |cand;
    limit = MAX_HOLD != 0 && hcnt == HW'(MAX_HOLD) && any;
    arb = state == IDLE || !req_i[gnt_idx_o] || limit;
    start = mode_i ? ptr : '0;
    win = '0;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(start) + N - k) % N);
      if (cand[j]) win = j;
    end
    state_n = arb ? (any ? GRANT : IDLE) : state;
    gnt_n = arb ? (any ? N'(1) << win : '0) : gnt_o;
    idx_n = arb ? (any ? win : '0) : gnt_idx_o;
    ptr_n = arb && any ? win : ptr;
    hcnt_n = arb ? (any ? HW'(1) : '0)
                 : (MAX_HOLD != 0 && hcnt != HW'(MAX_HOLD) ? hcnt + HW'(1) : hcnt);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      gnt_o <= '0;
      gnt_idx_o <= '0;
      ptr <= '0;
      hcnt <= '0;
    end else begin
      state <= state_n;
      gnt_o <= gnt_n;
      gnt_idx_o <= idx_n;
      ptr <= ptr_n;
      hcnt <= hcnt_n;
    end
  end
  assign gnt_vld_o = |gnt_o;
endmodule
